pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx_pkg.sv | 19 +
 rtl/pattern_tx_shreg.sv | 34 +++
 rtl/pattern_tx.sv | 165 ++++++++++++++++
 tb/tb_pattern_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg -- shared definitions for the pattern_tx serializer.
//   PAT_W_DEF / RPT_W_DEF : default pattern width and repeat-count width.
//   state_t / ST_*        : FSM state encoding. ST_PARITY exists only when
//                           PATTERN_TX_PARITY_EN is defined.
package pattern_tx_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int RPT_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
`ifdef PATTERN_TX_PARITY_EN
  localparam state_t ST_PARITY = 2'd2;
`endif
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/pattern_tx_shreg.sv
// pattern_tx_shreg -- parallel-load, MSB-out, shift-left register.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset, clears the register
//   i_load  : load i_data (has priority over i_shift)
//   i_shift : shift left by one, zero fill
//   i_data  : parallel load value
//   o_msb   : current MSB (the bit being emitted)
module pattern_tx_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[W-1];

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx -- serial pattern transmitter. Sends bits PAT_W-1 down to
// PAT_W-1-len of a captured pattern, MSB first, repeat_cnt+1 times back to
// back, then pulses done for one cycle.
// Optional feature: define PATTERN_TX_PARITY_EN to append an even-parity bit
// (XOR of the pass's bits) after every pass.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : transfer request, sampled in IDLE or DONE only
//   pattern     : bits to send, MSB first
//   len         : number of bits minus 1
//   repeat_cnt  : extra passes after the first ("repeat" is a keyword)
//   dout/dvalid : serial bit and its qualifier; both 0 when not emitting
//   busy        : transfer in progress (SHIFT or PARITY)
//   done        : one-cycle pulse in DONE
//   dbg_state   : current FSM state
// Handshake: a start seen in IDLE/DONE at a rising edge is accepted on that
// edge; the first bit appears in the next cycle. While busy, start and the
// data inputs are ignored.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pattern,
  input  logic [$clog2(PAT_W)-1:0] len,
  input  logic [RPT_W-1:0]         repeat_cnt,
  output logic                     dout,
  output logic                     dvalid,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int LEN_W = $clog2(PAT_W);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [RPT_W-1:0] r_pass_cnt;
`ifdef PATTERN_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_accept;
  logic             w_next_pass;
  logic             w_load;
  logic             w_shift;
  logic [PAT_W-1:0] w_load_data;
  logic             w_msb;

  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;

  // A new pass reloads the shift register from the captured pattern.
`ifdef PATTERN_TX_PARITY_EN
  assign w_next_pass = (r_state == ST_PARITY) && (r_pass_cnt != '0);
`else
  assign w_next_pass = (r_state == ST_SHIFT) && (r_bit_cnt == '0) && (r_pass_cnt != '0);
`endif

  assign w_load      = w_accept || w_next_pass;
  assign w_load_data = w_accept ? pattern : r_pat;
  assign w_shift     = (r_state == ST_SHIFT) && (r_bit_cnt != '0);

  pattern_tx_shreg #(.W(PAT_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pat      <= '0;
      r_len      <= '0;
      r_bit_cnt  <= '0;
      r_pass_cnt <= '0;
`ifdef PATTERN_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_pat      <= pattern;
            r_len      <= len;
            r_bit_cnt  <= len;
            r_pass_cnt <= repeat_cnt;
`ifdef PATTERN_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
            r_state    <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
`ifdef PATTERN_TX_PARITY_EN
          r_par <= r_par ^ w_msb;
          if (r_bit_cnt == '0) begin
            r_state <= ST_PARITY;
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
`else
          if (r_bit_cnt == '0) begin
            if (r_pass_cnt != '0) begin
              r_pass_cnt <= r_pass_cnt - 1'b1;
              r_bit_cnt  <= r_len;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
`endif
        end
`ifdef PATTERN_TX_PARITY_EN
        ST_PARITY: begin
          if (r_pass_cnt != '0) begin
            r_pass_cnt <= r_pass_cnt - 1'b1;
            r_bit_cnt  <= r_len;
            r_par      <= 1'b0;
            r_state    <= ST_SHIFT;
          end else begin
            r_state <= ST_DONE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout   = 1'b0;
    dvalid = 1'b0;
    if (r_state == ST_SHIFT) begin
      dout   = w_msb;
      dvalid = 1'b1;
    end
`ifdef PATTERN_TX_PARITY_EN
    if (r_state == ST_PARITY) begin
      dout   = r_par;
      dvalid = 1'b1;
    end
`endif
  end

`ifdef PATTERN_TX_PARITY_EN
  assign busy = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
`else
  assign busy = (r_state == ST_SHIFT);
`endif
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx -- self-checking bench for pattern_tx (default PAT_W=8,
// RPT_W=4). Honours PATTERN_TX_PARITY_EN. Output bundle compared each cycle
// is {done, busy, dvalid, dout}.
module tb_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [2:0] len = '0;
  logic [3:0] repeat_cnt = '0;
  logic       dout, dvalid, busy, done;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  pattern_tx #(.PAT_W(8), .RPT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .repeat_cnt (repeat_cnt),
    .dout       (dout),
    .dvalid     (dvalid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of expected output bundles for upcoming cycles.
  logic [3:0] exp_q[$];
  logic [3:0] cur = 4'b0000;

  typedef struct {
    logic       st;
    logic [7:0] pat;
    logic [2:0] ln;
    logic [3:0] rp;
    logic       rs;
    logic [3:0] exp_o;
    logic [1:0] exp_s;
  } vec_t;

  vec_t tbl[$];

  localparam logic [3:0] O_I  = 4'b0000;
  localparam logic [3:0] O_D  = 4'b1000;
  localparam logic [3:0] O_B1 = 4'b0111;
  localparam logic [3:0] O_B0 = 4'b0110;

  function automatic vec_t mk(logic st, logic [7:0] pat, logic [2:0] ln,
                              logic [3:0] rp, logic rs, logic [3:0] eo,
                              logic [1:0] es);
    vec_t v;
    v.st = st; v.pat = pat; v.ln = ln; v.rp = rp; v.rs = rs;
    v.exp_o = eo; v.exp_s = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b time=%0t", name, act, exp, $time);
    end
  endtask

  // Expected cycles of a whole transfer, straight from the rules:
  // (repeat+1) passes of the top len+1 bits, optional parity, then done.
  task automatic model_load(input logic [7:0] pat, input logic [2:0] ln, input logic [3:0] rp);
    for (int p = 0; p <= int'(rp); p++) begin
      logic par;
      par = 1'b0;
      for (int i = 0; i <= int'(ln); i++) begin
        exp_q.push_back({3'b011, pat[7-i]});
        par = par ^ pat[7-i];
      end
`ifdef PATTERN_TX_PARITY_EN
      exp_q.push_back({3'b011, par});
`endif
    end
    exp_q.push_back(O_D);
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    start = v.st; pattern = v.pat; len = v.ln; repeat_cnt = v.rp; rst = v.rs;
    @(negedge clk);
    chk("model", {done, busy, dvalid, dout}, cur);
    if (use_tbl) begin
      chk("tbl_out", {done, busy, dvalid, dout}, v.exp_o);
      chk("tbl_state", {2'b00, dbg_state}, {2'b00, v.exp_s});
    end
    @(posedge clk);
    if (v.rs) begin
      exp_q.delete();
    end else if (!cur[2] && v.st) begin
      exp_q.delete();
      model_load(v.pat, v.ln, v.rp);
    end
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : O_I;
    #1;
  endtask

  task automatic build_table();
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_I, 0));
`ifdef PATTERN_TX_PARITY_EN
    // 1011 -> 1,0,1,1, parity 1, done
    tbl.push_back(mk(1, 8'hB0, 3, 0, 0, O_I, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_D, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_I, 0));
    // len=0: bit 1, parity 1, done
    tbl.push_back(mk(1, 8'h80, 0, 0, 0, O_I, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_D, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_I, 0));
`else
    // 1011, len=3 -> 1,0,1,1 in cycles 1-4, done in cycle 5
    tbl.push_back(mk(1, 8'hB0, 3, 0, 0, O_I, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_D, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_I, 0));
    // len=0, then start during done: back-to-back 2-bit "01"
    tbl.push_back(mk(1, 8'h80, 0, 0, 0, O_I, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(1, 8'h40, 1, 0, 0, O_D, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_D, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_I, 0));
`endif
    // reset in cycle 3 of a 4-bit transfer, then a new start is accepted
    tbl.push_back(mk(1, 8'hB0, 3, 0, 0, O_I, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B0, 1));
    tbl.push_back(mk(1, 8'h00, 0, 0, 1, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_I, 0));
    tbl.push_back(mk(1, 8'hC0, 1, 0, 0, O_I, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, O_B1, 1));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cur = O_I;

    build_table();
    foreach (tbl[i]) step(tbl[i], 1'b1);
    for (int i = 0; i < 6; i++) step(mk(0, 8'h00, 0, 0, 0, O_I, 0), 1'b0);

    // 0100, len=3, repeat=2: three gap-free passes
    step(mk(1, 8'h40, 3, 2, 0, O_I, 0), 1'b0);
    for (int i = 0; i < 18; i++) step(mk(0, 8'h00, 0, 0, 0, O_I, 0), 1'b0);

    // start held high while data inputs change every cycle
    for (int i = 0; i < 40; i++) begin
      v = mk(1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
             4'($urandom_range(0, 2)), 0, O_I, 0);
      step(v, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(mk(0, 8'h00, 0, 0, 0, O_I, 0), 1'b0);

    // full-width pattern
    step(mk(1, 8'hA5, 7, 1, 0, O_I, 0), 1'b0);
    for (int i = 0; i < 22; i++) step(mk(0, 8'h00, 0, 0, 0, O_I, 0), 1'b0);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      v = mk(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)),
             3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
             ($urandom_range(0, 59) == 0), O_I, 0);
      step(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
